// File: rtl/thirtytwo_bit_subtract.sv
// Registered 32-bit two's-complement subtractor (A - B) built on a two-level carry-lookahead adder.
// Optional sticky overflow flag when SUB_STICKY_OVF_EN is defined.
module thirtytwo_bit_subtract (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] S,
    output logic        overflow,
    output logic        isLessThan,
    output logic        isNotEqual
`ifdef SUB_STICKY_OVF_EN
    ,
    output logic        overflow_sticky
`endif
);

    typedef struct packed {
        logic [7:0] gen;
        logic [7:0] prop;
    } prefixT;

    // Prefix generate/propagate across bits 0..i of one 8-bit group.
    function automatic prefixT groupPrefix(input logic [7:0] g, input logic [7:0] p);
        prefixT r;
        r.gen[0]  = g[0];
        r.prop[0] = p[0];
        for (int i = 1; i < 8; i++) begin
            r.gen[i]  = g[i] | (p[i] & r.gen[i-1]);
            r.prop[i] = p[i] & r.prop[i-1];
        end
        return r;
    endfunction

    logic [31:0] bInv;
    logic [31:0] bitGen;
    logic [31:0] bitProp;
    logic [3:0]  groupGen;
    logic [3:0]  groupProp;
    logic [3:0]  groupCarry;
    logic [31:0] bitCarry;
    logic [31:0] diff;
    logic        diffOverflow;
    logic        diffLess;
    logic        diffNotEqual;
    prefixT      prefix [4];

    // Subtraction as A + ~B + 1: the +1 enters as carry-in of group 0.
    assign bInv    = ~B;
    assign bitGen  = A & bInv;
    assign bitProp = A ^ bInv;

    // NOTE: every always_comb output is assigned on all paths so no latch is inferred.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            prefix[k]    = groupPrefix(bitGen[8*k +: 8], bitProp[8*k +: 8]);
            groupGen[k]  = prefix[k].gen[7];
            groupProp[k] = prefix[k].prop[7];
        end
    end

    // Second-level lookahead: group carries derived in parallel from group G/P.
    always_comb begin
        groupCarry[0] = 1'b1;
        groupCarry[1] = groupGen[0] | (groupProp[0] & groupCarry[0]);
        groupCarry[2] = groupGen[1]
                      | (groupProp[1] & groupGen[0])
                      | (groupProp[1] & groupProp[0] & groupCarry[0]);
        groupCarry[3] = groupGen[2]
                      | (groupProp[2] & groupGen[1])
                      | (groupProp[2] & groupProp[1] & groupGen[0])
                      | (groupProp[2] & groupProp[1] & groupProp[0] & groupCarry[0]);
    end

    always_comb begin
        bitCarry = '0;
        for (int k = 0; k < 4; k++) begin
            bitCarry[8*k] = groupCarry[k];
            for (int i = 1; i < 8; i++) begin
                bitCarry[8*k + i] = prefix[k].gen[i-1] | (prefix[k].prop[i-1] & groupCarry[k]);
            end
        end
    end

    assign diff         = bitProp ^ bitCarry;
    assign diffOverflow = (A[31] != B[31]) && (diff[31] != A[31]);
    assign diffLess     = diff[31] ^ diffOverflow;
    assign diffNotEqual = |diff;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            S          <= '0;
            overflow   <= 1'b0;
            isLessThan <= 1'b0;
            isNotEqual <= 1'b0;
        end else if (en) begin
            S          <= diff;
            overflow   <= diffOverflow;
            isLessThan <= diffLess;
            isNotEqual <= diffNotEqual;
        end
    end

`ifdef SUB_STICKY_OVF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_sticky <= 1'b0;
        end else if (en && diffOverflow) begin
            overflow_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_thirtytwo_bit_subtract.sv
// Self-checking bench: directed corner cases plus randomized traffic against a plain-arithmetic model.
// Define SUB_STICKY_OVF_EN to also check the sticky overflow output.
module tb_thirtytwo_bit_subtract;

    logic        clock;
    logic        reset;
    logic        en;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] S;
    logic        overflow;
    logic        isLessThan;
    logic        isNotEqual;
`ifdef SUB_STICKY_OVF_EN
    logic        overflow_sticky;
`endif

    int vectors;
    int miscompares;

    // Expected register contents.
    logic [31:0] expS;
    logic        expOvf;
    logic        expLess;
    logic        expNe;
    logic        expSticky;

    thirtytwo_bit_subtract dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .A          (A),
        .B          (B),
        .S          (S),
        .overflow   (overflow),
        .isLessThan (isLessThan),
        .isNotEqual (isNotEqual)
`ifdef SUB_STICKY_OVF_EN
        ,
        .overflow_sticky (overflow_sticky)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference behaviour from signed integer arithmetic.
    task automatic modelEdge(input logic r, input logic e, input logic [31:0] a, input logic [31:0] b);
        longint wide;
        if (r) begin
            expS = '0; expOvf = 0; expLess = 0; expNe = 0; expSticky = 0;
        end else if (e) begin
            wide    = longint'($signed(a)) - longint'($signed(b));
            expS    = a - b;
            expOvf  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            expLess = $signed(a) < $signed(b);
            expNe   = a != b;
            if (expOvf) expSticky = 1'b1;
        end
    endtask

    task automatic checkAll(input string tag);
        check({tag, ".S"},          S,                   expS);
        check({tag, ".overflow"},   {31'b0, overflow},   {31'b0, expOvf});
        check({tag, ".isLessThan"}, {31'b0, isLessThan}, {31'b0, expLess});
        check({tag, ".isNotEqual"}, {31'b0, isNotEqual}, {31'b0, expNe});
`ifdef SUB_STICKY_OVF_EN
        check({tag, ".sticky"},     {31'b0, overflow_sticky}, {31'b0, expSticky});
`endif
    endtask

    // Drive between edges, take one rising edge, then sample 1 time unit later.
    task automatic step(input string tag, input logic r, input logic e, input logic [31:0] a, input logic [31:0] b);
        reset = r; en = e; A = a; B = b;
        @(posedge clock);
        modelEdge(r, e, a, b);
        #1;
        checkAll(tag);
    endtask

    function automatic logic [31:0] pickOperand();
        logic [31:0] corners [6];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_00FF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom();
    endfunction

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b1; en = 1'b0; A = '0; B = '0;
        expS = '0; expOvf = 0; expLess = 0; expNe = 0; expSticky = 0;
        #2;

        step("reset",      1, 0, 32'h0, 32'h0);
        step("one_two",    0, 1, 32'd1, 32'd2);
        step("wrap",       0, 1, 32'h0, 32'h1);
        step("min_sub1",   0, 1, 32'h8000_0000, 32'h1);
        step("post_ovf",   0, 1, 32'd10, 32'd4);
        step("max_subm1",  0, 1, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        step("equal",      0, 1, 32'd5, 32'd5);
        step("load6",      0, 1, 32'd9, 32'd3);
        for (int i = 0; i < 3; i++) step("hold", 0, 0, 32'd1, 32'd2);
        step("reload",     0, 1, 32'd1, 32'd2);

        // Inputs toggled away from the edge must not reach the outputs.
        A = 32'h1234_5678; B = 32'h0000_0001; en = 1'b1;
        #2;
        checkAll("midcycle");

        step("rst_pri",    1, 1, 32'd1, 32'd2);
        step("after_rst",  0, 1, 32'd1, 32'd2);
        step("carry_chain",0, 1, 32'h0001_0000, 32'h0000_0001);
        step("grp_border", 0, 1, 32'h0100_0000, 32'h00FF_FFFF);

        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 pickOperand(), pickOperand());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/thirtytwo_bit_subtract.md
THIRTYTWO_BIT_SUBTRACT -- requirements
Module: thirtytwo_bit_subtract

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32 bits.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 en  input  1  update enable; outputs reload only when high.
REQ-005 A  input  32  minuend, two's complement.
REQ-006 B  input  32  subtrahend, two's complement.
REQ-007 S  output  32  registered difference A - B.
REQ-008 overflow  output  1  registered signed-overflow flag.
REQ-009 isLessThan  output  1  registered signed A < B flag.
REQ-010 isNotEqual  output  1  registered A != B flag.
REQ-011 overflow_sticky  output  1  present only when SUB_STICKY_OVF_EN is defined (see Configuration).

Function
REQ-012 The block SHALL compute the difference combinationally as A + ~B + 1, modulo 2^32, with no carry-out port.
REQ-013 The adder SHALL be built from four 8-bit carry-lookahead groups with group generate/propagate; carry-in to group 0 is 1.
REQ-014 overflow SHALL equal (A[31] != B[31]) && (diff[31] != A[31]).
REQ-015 isLessThan SHALL equal diff[31] XOR overflow, i.e. a correct signed compare even when overflow is set.
REQ-016 isNotEqual SHALL equal the OR-reduction of all 32 diff bits.
REQ-017 On a rising edge with reset low and en high, S and all flags SHALL load the values computed from A and B sampled at that edge: latency exactly 1 cycle.
REQ-018 On a rising edge with reset low and en low, S and all flags SHALL hold their previous values.
REQ-019 Inputs changing between edges SHALL have no effect on outputs until the next qualifying edge.
REQ-020 Wrap-around: A=0x00000000, B=0x00000001 SHALL give S=0xFFFFFFFF with overflow 0.
REQ-021 The block SHALL contain no state beyond the output registers (plus the sticky flag when configured).

Reset
REQ-022 When reset is high at a rising edge, S SHALL become 0x00000000 and overflow, isLessThan, isNotEqual SHALL become 0, regardless of en.
REQ-023 Reset SHALL take priority over en; asserting reset mid-stream SHALL discard the value computed in that cycle.
REQ-024 The first qualifying edge after reset deasserts SHALL load normal results; there is no extra recovery cycle.

Configuration
REQ-025 With macro SUB_STICKY_OVF_EN defined, output overflow_sticky SHALL exist, reset to 0, and set to 1 on any edge where en is high and the computed overflow is 1, holding 1 until reset.
REQ-026 Without SUB_STICKY_OVF_EN, the port overflow_sticky and its register SHALL be absent; all other behaviour is identical.

Verification
REQ-027 A=1, B=2, en=1, one edge -> S=0xFFFFFFFF, overflow=0, isLessThan=1, isNotEqual=1.
REQ-028 A=0x80000000, B=0x00000001 -> S=0x7FFFFFFF, overflow=1, isLessThan=1, isNotEqual=1; overflow_sticky=1 and stays 1 on later non-overflow inputs (macro defined).
REQ-029 A=0x7FFFFFFF, B=0xFFFFFFFF -> S=0x80000000, overflow=1, isLessThan=0, isNotEqual=1.
REQ-030 A=B=0x00000005 -> S=0, overflow=0, isLessThan=0, isNotEqual=0.
REQ-031 Load A=9, B=3 (S=6), then en=0 with A=1, B=2 for 3 edges -> S stays 0x00000006 and flags unchanged; en=1 -> S=0xFFFFFFFF on the next edge.
REQ-032 reset=1 with en=1, A=1, B=2 -> all outputs 0 (overflow_sticky 0) after that edge; outputs match REQ-027 one edge after reset drops.
